// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences add/sub/slt/nor/addi/andi/lui/lw/sw/beq/bne/j/jr/jal/nop
// over a shared ALU/memory datapath, with a memory ready handshake, access timeout and sticky trap.
module mips_multicycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned CNT_W         = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_in,
  input  logic [5:0] func_in,
  input  logic       mem_ready_in,
  output logic       pcWrite_out,
  output logic       pcWriteCond_out,
  output logic       bne_out,
  output logic       IorD_out,
  output logic       irWrite_out,
  output logic       memRead_out,
  output logic       memWrite_out,
  output logic       memToReg_out,
  output logic       regDst_out,
  output logic       regWrite_out,
  output logic       jal_out,
  output logic       ALUSrcA_out,
  output logic [1:0] ALUSrcB_out,
  output logic       extCntrl_out,
  output logic [3:0] ALUCntrl_out,
  output logic [1:0] PCSource_out,
  output logic [1:0] trap_cause_out,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JUMP_REG = 4'd13,
    S_JAL      = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t           state, state_nxt;
  logic [1:0]       cause, cause_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready;
  logic             mem_state;
  logic             timeout_hit;

  assign ready       = (MEM_HANDSHAKE != 0) ? mem_ready_in : 1'b1;
  assign mem_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      cause    <= CAUSE_NONE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      // Any state change clears the count, which covers entry into each memory state.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (mem_state && !ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state and trap-cause logic
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    unique case (state)
      S_RST: state_nxt = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (ready) begin
          if (state == S_FETCH)       state_nxt = S_DECODE;
          else if (state == S_MEM_RD) state_nxt = S_MEM_WB;
          else                        state_nxt = S_FETCH;
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (op_in)
          6'h00: begin
            unique case (func_in)
              6'h20, 6'h22, 6'h2a, 6'h27: state_nxt = S_EXEC_R;
              6'h08:                      state_nxt = S_JUMP_REG;
              6'h00:                      state_nxt = S_FETCH;
              default: begin
                state_nxt = S_TRAP;
                cause_nxt = CAUSE_ILLEGAL;
              end
            endcase
          end
          6'h08, 6'h0c, 6'h0f: state_nxt = S_EXEC_I;
          6'h23, 6'h2b:        state_nxt = S_MEM_ADDR;
          6'h04, 6'h05:        state_nxt = S_BRANCH;
          6'h02:               state_nxt = S_JUMP;
          6'h03:               state_nxt = S_JAL;
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R:   state_nxt = S_WB_R;
      S_EXEC_I:   state_nxt = S_WB_I;
      S_MEM_ADDR: state_nxt = (op_in == 6'h2b) ? S_MEM_WR : S_MEM_RD;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore output decode, refined by op/func where the datapath needs it
  always_comb begin
    pcWrite_out     = 1'b0;
    pcWriteCond_out = 1'b0;
    bne_out         = 1'b0;
    IorD_out        = 1'b0;
    irWrite_out     = 1'b0;
    memRead_out     = 1'b0;
    memWrite_out    = 1'b0;
    memToReg_out    = 1'b0;
    regDst_out      = 1'b0;
    regWrite_out    = 1'b0;
    jal_out         = 1'b0;
    ALUSrcA_out     = 1'b0;
    ALUSrcB_out     = 2'b00;
    extCntrl_out    = 1'b0;
    ALUCntrl_out    = ALU_AND;
    PCSource_out    = 2'b00;
    unique case (state)
      S_FETCH: begin
        memRead_out  = 1'b1;
        ALUSrcB_out  = 2'b01;
        ALUCntrl_out = ALU_ADD;
        irWrite_out  = ready;
        pcWrite_out  = ready;
      end
      S_DECODE: begin
        ALUSrcB_out  = 2'b11;
        extCntrl_out = 1'b1;
        ALUCntrl_out = ALU_ADD;
      end
      S_EXEC_R: begin
        ALUSrcA_out = 1'b1;
        unique case (func_in)
          6'h22:   ALUCntrl_out = ALU_SUB;
          6'h2a:   ALUCntrl_out = ALU_SLT;
          6'h27:   ALUCntrl_out = ALU_NOR;
          default: ALUCntrl_out = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        regDst_out   = 1'b1;
        regWrite_out = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA_out = 1'b1;
        ALUSrcB_out = 2'b10;
        unique case (op_in)
          6'h0c:   ALUCntrl_out = ALU_AND;
          6'h0f:   ALUCntrl_out = ALU_LUI;
          default: begin
            ALUCntrl_out = ALU_ADD;
            extCntrl_out = 1'b1;
          end
        endcase
      end
      S_WB_I: regWrite_out = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA_out  = 1'b1;
        ALUSrcB_out  = 2'b10;
        extCntrl_out = 1'b1;
        ALUCntrl_out = ALU_ADD;
      end
      S_MEM_RD: begin
        IorD_out    = 1'b1;
        memRead_out = 1'b1;
      end
      S_MEM_WB: begin
        memToReg_out = 1'b1;
        regWrite_out = 1'b1;
      end
      S_MEM_WR: begin
        IorD_out     = 1'b1;
        memWrite_out = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_out     = 1'b1;
        ALUCntrl_out    = ALU_SUB;
        pcWriteCond_out = 1'b1;
        PCSource_out    = 2'b01;
        bne_out         = (op_in == 6'h05);
      end
      S_JUMP: begin
        pcWrite_out  = 1'b1;
        PCSource_out = 2'b10;
      end
      S_JUMP_REG: begin
        pcWrite_out  = 1'b1;
        PCSource_out = 2'b11;
      end
      S_JAL: begin
        pcWrite_out  = 1'b1;
        PCSource_out = 2'b10;
        regWrite_out = 1'b1;
        jal_out      = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_cause_out = cause;
  assign state_out      = state;

endmodule
